biriscv_mulf: RTL and testbench
===============================

// Module: biriscv_mulf
// PURPOSE
//  Iterative multi-cycle multiplier for RV32M MUL/MULH/MULHSU/MULHU, issued alongside the exec stage.
//  Produces mulf_complete_o/mulf_result_o, which drive the exec stage's writeback override (mulf_complete_i/mulf_result_i).
//  Stalls issue via mulf_busy_o while an operation is in flight.
// PARAMETERS
//  MUL_BITS_PER_CYCLE  2  multiplier bits retired per RUN cycle; legal 1,2,4. ITER = 32/MUL_BITS_PER_CYCLE.
// PORTS
//  clk_i                input   1   clock, all state on rising edge
//  rst_ni               input   1   asynchronous reset, active-low
//  opcode_valid_i       input   1   issue slot holds a valid instruction
//  opcode_opcode_i      input  32   instruction word
//  opcode_rd_idx_i      input   5   destination register
//  opcode_ra_operand_i  input  32   rs1 value (multiplicand)
//  opcode_rb_operand_i  input  32   rs2 value (multiplier)
//  hold_i               input   1   pipeline stall: freeze all state
//  flush_i              input   1   abort in-flight op (branch/exception)
//  mulf_accept_o        output  1   combinational: op accepted this cycle
//  mulf_busy_o          output  1   op in RUN/FIN; issue must not present another mul
//  mulf_complete_o      output  1   result valid (one-cycle pulse, extended by hold_i)
//  mulf_result_o        output 32   result; held stable until next accept
//  mulf_rd_idx_o        output  5   rd of completed op; held with result
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=IDLE, all outputs 0, accumulators 0.
//  Decode: is_mul = opcode[6:0]=0110011 & funct7=0000001 & funct3[2]=0; funct3[1:0] selects
//    00 MUL (low 32), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high).
//  Accept: mulf_accept_o = opcode_valid_i & is_mul & ~hold_i & ~flush_i & state in {IDLE,DONE}.
//  States: IDLE -> RUN on accept; RUN counts ITER cycles -> FIN; FIN (1 cycle) -> DONE;
//    DONE (1 cycle) -> IDLE, or -> RUN if accept same cycle (back-to-back allowed).
//  Datapath: on accept latch |a|,|b| (two's-complement magnitude when operand signed for op),
//    sign_neg = sign_a ^ sign_b (signed operands only), op, rd. RUN: unsigned shift-add,
//    MUL_BITS_PER_CYCLE multiplier bits per cycle into 64-bit product. FIN: negate 64-bit product
//    if sign_neg, select [31:0] (MUL) or [63:32] (others), register into mulf_result_o.
//  Magnitude of 0x80000000 is 0x80000000 as unsigned 32-bit: no overflow, arithmetic is exact.
//  Latency: accept in cycle N -> mulf_complete_o high in cycle N+ITER+2 (default N+18).
//  mulf_busy_o = state in {RUN,FIN}; 0 in IDLE and DONE.
//  hold_i=1: no state/counter/output change; complete stays high if in DONE; no accept.
//  flush_i=1 (priority over hold_i): state->IDLE next edge, complete suppressed, result/rd retain old value.
//  flush_i in DONE: complete deasserts next cycle; result already presented is not withdrawn this cycle.
//  opcode_valid_i with non-mul or while busy: ignored (no accept).
//  Async reset mid-operation: immediate return to reset values, no complete.
// STRUCTURE
//  Shared package/defines (biriscv_defs.v): INST_MUL/MULH/MULHSU/MULHU values+masks,
//    MULF state encodings (IDLE,RUN,FIN,DONE).
//  One sub-module: biriscv_mulf_step - combinational partial-product step
//    (acc, multiplicand, MUL_BITS_PER_CYCLE multiplier bits -> next acc). FSM, counter, sign
//    handling, output registers stay in biriscv_mulf.
// TESTING
//  MUL 7 x 6, rd=5 -> complete exactly 18 cycles after accept, result 0x0000002A, rd_idx 5, busy 1 for 17 cycles.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF(-1) x 0xFFFFFFFF -> 0xFFFFFFFF; MUL -3 x 5 -> 0xFFFFFFF1.
//  hold_i high 5 cycles mid-RUN -> complete at N+23, same result; hold during DONE -> complete stays high.
//  flush_i at cycle N+4 -> no complete, busy 0 next cycle; next MUL 2x3 -> 0x6 with normal latency.
//  Back-to-back: new MUL accepted in DONE cycle -> second complete 18 cycles later; rst_ni low mid-RUN -> outputs 0 at once.

Source files
------------

// File: rtl/biriscv_mulf_pkg.sv
// Shared encodings for the iterative RV32M multiplier: instruction match values,
// operation selectors and FSM state encodings.
package biriscv_mulf_pkg;

  // Full match values and masks for the four multiply instructions.
  localparam logic [31:0] InstMul       = 32'h0200_0033;
  localparam logic [31:0] InstMulMask   = 32'hfe00_707f;
  localparam logic [31:0] InstMulh      = 32'h0200_1033;
  localparam logic [31:0] InstMulhMask  = 32'hfe00_707f;
  localparam logic [31:0] InstMulhsu    = 32'h0200_2033;
  localparam logic [31:0] InstMulhsuMask = 32'hfe00_707f;
  localparam logic [31:0] InstMulhu     = 32'h0200_3033;
  localparam logic [31:0] InstMulhuMask = 32'hfe00_707f;

  // Group match: OP opcode, funct7=0000001, funct3[2]=0 (excludes DIV/REM).
  localparam logic [31:0] InstMulGroup     = 32'h0200_0033;
  localparam logic [31:0] InstMulGroupMask = 32'hfe00_407f;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFin  = 2'b10,
    StDone = 2'b11
  } mulf_state_e;

  // rs1 is treated as signed for everything except MULHU.
  function automatic logic op_a_signed(input mul_op_e op);
    return op != OpMulhu;
  endfunction

  // rs2 is treated as signed only for MUL and MULH.
  function automatic logic op_b_signed(input mul_op_e op);
    return (op == OpMul) || (op == OpMulh);
  endfunction

endpackage

// File: rtl/biriscv_mulf_step.sv
// Combinational partial-product step: adds the multiplicand, weighted by each of the
// low multiplier bits presented this cycle, into the 64-bit accumulator.
module biriscv_mulf_step #(
  parameter int unsigned MUL_BITS_PER_CYCLE = 2
) (
  input  logic [63:0]                   acc_i,
  input  logic [63:0]                   mcand_i,
  input  logic [MUL_BITS_PER_CYCLE-1:0] bits_i,
  output logic [63:0]                   acc_o
);

  // Unsigned shift-add over the multiplier bits retired this cycle.
  always_comb begin
    acc_o = acc_i;
    for (int unsigned i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (bits_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/biriscv_mulf.sv
// Iterative multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU). Operands are reduced
// to magnitudes on accept, multiplied unsigned over Iter RUN cycles, then sign-corrected
// and registered in FIN; DONE presents the result for one cycle.
module biriscv_mulf
  import biriscv_mulf_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        mulf_accept_o,
  output logic        mulf_busy_o,
  output logic        mulf_complete_o,
  output logic [31:0] mulf_result_o,
  output logic [4:0]  mulf_rd_idx_o
);

  localparam int unsigned Iter = 32 / MUL_BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(Iter);
  localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);

  mulf_state_e     state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     acc_q, acc_d;
  logic [63:0]     mcand_q, mcand_d;
  logic [31:0]     mplier_q, mplier_d;
  logic            sign_neg_q, sign_neg_d;
  mul_op_e         op_q, op_d;
  logic [4:0]      rd_pend_q, rd_pend_d;
  logic [31:0]     result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  logic            is_mul;
  mul_op_e         op_in;
  logic            a_neg, b_neg;
  logic [31:0]     a_mag, b_mag;
  logic [63:0]     step_acc;
  logic [63:0]     product;

  // Instruction decode and operand magnitude extraction for the issue slot.
  always_comb begin
    is_mul = (opcode_opcode_i & InstMulGroupMask) == InstMulGroup;
    op_in  = mul_op_e'(opcode_opcode_i[13:12]);
    a_neg  = op_a_signed(op_in) & opcode_ra_operand_i[31];
    b_neg  = op_b_signed(op_in) & opcode_rb_operand_i[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_mag  = a_neg ? (~opcode_ra_operand_i + 32'd1) : opcode_ra_operand_i;
    b_mag  = b_neg ? (~opcode_rb_operand_i + 32'd1) : opcode_rb_operand_i;
    mulf_accept_o = opcode_valid_i & is_mul & ~hold_i & ~flush_i &
                    ((state_q == StIdle) || (state_q == StDone));
  end

  biriscv_mulf_step #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .bits_i (mplier_q[MUL_BITS_PER_CYCLE-1:0]),
    .acc_o  (step_acc)
  );

  // Sign-corrected final product, consumed only in FIN.
  always_comb begin
    product = sign_neg_q ? (~acc_q + 64'd1) : acc_q;
  end

  // Next-state: flush beats hold; hold freezes everything.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sign_neg_d = sign_neg_q;
    op_d       = op_q;
    rd_pend_d  = rd_pend_q;
    result_d   = result_q;
    rd_d       = rd_q;

    if (flush_i) begin
      state_d = StIdle;
    end else if (!hold_i) begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (mulf_accept_o) begin
            state_d    = StRun;
            count_d    = '0;
            acc_d      = '0;
            mcand_d    = {32'd0, a_mag};
            mplier_d   = b_mag;
            sign_neg_d = a_neg ^ b_neg;
            op_d       = op_in;
            rd_pend_d  = opcode_rd_idx_i;
          end
        end
        StRun: begin
          acc_d    = step_acc;
          mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
          mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
          count_d  = count_q + 1'b1;
          if (count_q == LastCnt) begin
            state_d = StFin;
          end
        end
        StFin: begin
          result_d = (op_q == OpMul) ? product[31:0] : product[63:32];
          rd_d     = rd_pend_q;
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      count_q    <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      sign_neg_q <= 1'b0;
      op_q       <= OpMul;
      rd_pend_q  <= '0;
      result_q   <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      sign_neg_q <= sign_neg_d;
      op_q       <= op_d;
      rd_pend_q  <= rd_pend_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
    end
  end

  // Status and result outputs.
  always_comb begin
    mulf_busy_o     = (state_q == StRun) || (state_q == StFin);
    mulf_complete_o = (state_q == StDone);
    mulf_result_o   = result_q;
    mulf_rd_idx_o   = rd_q;
  end

endmodule

// File: tb/tb_biriscv_mulf.sv
// Directed self-checking bench for biriscv_mulf with hand-computed expected values.
module tb_biriscv_mulf;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        opcode_valid_i = 1'b0;
  logic [31:0] opcode_opcode_i = '0;
  logic [4:0]  opcode_rd_idx_i = '0;
  logic [31:0] opcode_ra_operand_i = '0;
  logic [31:0] opcode_rb_operand_i = '0;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        mulf_accept_o;
  logic        mulf_busy_o;
  logic        mulf_complete_o;
  logic [31:0] mulf_result_o;
  logic [4:0]  mulf_rd_idx_o;

  int n_checks = 0;
  int n_fail = 0;

  biriscv_mulf #(
    .MUL_BITS_PER_CYCLE(2)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .opcode_valid_i     (opcode_valid_i),
    .opcode_opcode_i    (opcode_opcode_i),
    .opcode_rd_idx_i    (opcode_rd_idx_i),
    .opcode_ra_operand_i(opcode_ra_operand_i),
    .opcode_rb_operand_i(opcode_rb_operand_i),
    .hold_i             (hold_i),
    .flush_i            (flush_i),
    .mulf_accept_o      (mulf_accept_o),
    .mulf_busy_o        (mulf_busy_o),
    .mulf_complete_o    (mulf_complete_o),
    .mulf_result_o      (mulf_result_o),
    .mulf_rd_idx_o      (mulf_rd_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_op(input logic [2:0] f3);
    return 32'h0200_0033 | ({29'd0, f3} << 12);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present an op in the current cycle (N), check accept, leave it at cycle N+1.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    opcode_valid_i      = 1'b1;
    opcode_opcode_i     = mk_op(f3);
    opcode_ra_operand_i = a;
    opcode_rb_operand_i = b;
    opcode_rd_idx_i     = rd;
    #3;
    check({tag, "_accept"}, {31'd0, mulf_accept_o}, 32'd1);
    step();
    opcode_valid_i = 1'b0;
  endtask

  // Wait for complete; cyc counts cycles since accept, busy counts busy cycles seen.
  task automatic wait_complete(input int start, output int cyc, output int busy);
    cyc  = start;
    busy = 0;
    while (!mulf_complete_o && cyc < 100) begin
      if (mulf_busy_o) busy++;
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    int busy;
    issue(tag, f3, a, b, rd);
    wait_complete(1, lat, busy);
    check({tag, "_lat"}, 32'(lat), 32'd18);
    check({tag, "_res"}, mulf_result_o, exp);
    check({tag, "_rd"}, {27'd0, mulf_rd_idx_o}, {27'd0, rd});
    step();
    check({tag, "_pulse"}, {31'd0, mulf_complete_o}, 32'd0);
  endtask

  initial begin
    int lat;
    int busy;
    int seen;

    // Reset state.
    #12;
    check("rst_busy", {31'd0, mulf_busy_o}, 32'd0);
    check("rst_complete", {31'd0, mulf_complete_o}, 32'd0);
    check("rst_result", mulf_result_o, 32'd0);
    check("rst_rd", {27'd0, mulf_rd_idx_o}, 32'd0);
    step();
    rst_ni = 1'b1;
    step();

    // Non-mul and DIV encodings must not be accepted.
    opcode_valid_i  = 1'b1;
    opcode_opcode_i = 32'h0000_0033;
    #1;
    check("add_no_accept", {31'd0, mulf_accept_o}, 32'd0);
    opcode_opcode_i = 32'h0200_4033;
    #1;
    check("div_no_accept", {31'd0, mulf_accept_o}, 32'd0);
    opcode_valid_i = 1'b0;
    step();

    // MUL 7 x 6 with latency and busy-duration checks.
    issue("mul7x6", 3'b000, 32'd7, 32'd6, 5'd5);
    check("busy_after_accept", {31'd0, mulf_busy_o}, 32'd1);
    opcode_valid_i  = 1'b1;
    opcode_opcode_i = mk_op(3'b000);
    #1;
    check("busy_no_accept", {31'd0, mulf_accept_o}, 32'd0);
    opcode_valid_i = 1'b0;
    wait_complete(1, lat, busy);
    check("mul7x6_lat", 32'(lat), 32'd18);
    check("mul7x6_busy", 32'(busy), 32'd17);
    check("mul7x6_res", mulf_result_o, 32'h0000_002A);
    check("mul7x6_rd", {27'd0, mulf_rd_idx_o}, 32'd5);
    check("done_not_busy", {31'd0, mulf_busy_o}, 32'd0);
    step();
    check("mul7x6_pulse", {31'd0, mulf_complete_o}, 32'd0);

    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    run_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFF1);

    // Hold for 5 cycles mid-RUN, then hold across DONE.
    issue("hold", 3'b000, 32'd7, 32'd6, 5'd9);
    step();
    step();
    hold_i = 1'b1;
    opcode_valid_i  = 1'b1;
    opcode_opcode_i = mk_op(3'b000);
    #1;
    check("hold_no_accept", {31'd0, mulf_accept_o}, 32'd0);
    opcode_valid_i = 1'b0;
    repeat (5) step();
    hold_i = 1'b0;
    wait_complete(8, lat, busy);
    check("hold_lat", 32'(lat), 32'd23);
    check("hold_res", mulf_result_o, 32'h0000_002A);
    hold_i = 1'b1;
    repeat (3) step();
    check("hold_done_complete", {31'd0, mulf_complete_o}, 32'd1);
    check("hold_done_res", mulf_result_o, 32'h0000_002A);
    hold_i = 1'b0;
    step();
    check("hold_release", {31'd0, mulf_complete_o}, 32'd0);

    // Flush at cycle N+4: no complete, result retained.
    issue("flush", 3'b000, 32'd100, 32'd100, 5'd12);
    repeat (3) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy", {31'd0, mulf_busy_o}, 32'd0);
    seen = 0;
    repeat (25) begin
      if (mulf_complete_o) seen++;
      step();
    end
    check("flush_no_complete", 32'(seen), 32'd0);
    check("flush_res_kept", mulf_result_o, 32'h0000_002A);
    check("flush_rd_kept", {27'd0, mulf_rd_idx_o}, 32'd9);
    run_op("after_flush", 3'b000, 32'd2, 32'd3, 5'd6, 32'h0000_0006);

    // Back-to-back: second op accepted in the DONE cycle of the first.
    issue("b2b_a", 3'b000, 32'd11, 32'd13, 5'd7);
    wait_complete(1, lat, busy);
    check("b2b_a_lat", 32'(lat), 32'd18);
    check("b2b_a_res", mulf_result_o, 32'd143);
    issue("b2b_b", 3'b011, 32'h0001_0000, 32'h0003_0000, 5'd8);
    wait_complete(1, lat, busy);
    check("b2b_b_lat", 32'(lat), 32'd18);
    check("b2b_b_res", mulf_result_o, 32'h0000_0003);
    check("b2b_b_rd", {27'd0, mulf_rd_idx_o}, 32'd8);
    step();

    // Async reset mid-RUN clears outputs immediately.
    issue("rst_mid", 3'b000, 32'd5, 32'd5, 5'd10);
    repeat (4) step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, mulf_busy_o}, 32'd0);
    check("rstmid_complete", {31'd0, mulf_complete_o}, 32'd0);
    check("rstmid_result", mulf_result_o, 32'd0);
    check("rstmid_rd", {27'd0, mulf_rd_idx_o}, 32'd0);
    step();
    rst_ni = 1'b1;
    seen = 0;
    repeat (25) begin
      if (mulf_complete_o) seen++;
      step();
    end
    check("rstmid_no_complete", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
